onehot_index_fifo: RTL
======================

Name: onehot_index_fifo

Overview:
- Consumes the one-hot left/right masks produced by the priority encoder stage (MSB-most and LSB-most set bit of a word).
- Converts each mask to a binary bit index with a zero-word flag and buffers results in a small first-word-fall-through FIFO.
- Presents results to a ready/valid consumer.
- Absorbs consumer back-pressure, since the encoder stage has no ready input; flags dropped words.

Parameters:
- WIDTH, 32, width of input masks; integer >= 2.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- arstn_i  in  1  asynchronous active-low reset
- data_left_i  in  WIDTH  one-hot mask of the highest set bit (all-zero if word was zero)
- data_right_i  in  WIDTH  one-hot mask of the lowest set bit (all-zero if word was zero)
- data_val_i  in  1  masks valid this cycle; no back-pressure to source
- left_idx_o  out  IDX_W  index of highest set bit
- right_idx_o  out  IDX_W  index of lowest set bit
- zero_o  out  1  source word was all-zero; indices are 0
- val_o  out  1  output entry valid (FIFO not empty)
- ready_i  in  1  consumer accepts entry when val_o && ready_i
- usedw_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow_o  out  1  sticky: at least one word dropped on full FIFO
- illegal_o  out  1  sticky: a valid mask had more than one bit set

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While arstn_i = 0: all state clears; val_o = 0, usedw_o = 0, overflow_o = 0, illegal_o = 0, stage-1 valid = 0.
  - left_idx_o, right_idx_o and zero_o read 0 while empty.
  - Deassertion mid-operation loses all buffered entries.
- Stage 1 (conversion register), captured on the edge where data_val_i = 1:
  - left_idx = position of set bit in data_left_i; right_idx likewise for data_right_i.
  - zero = (data_left_i == 0) && (data_right_i == 0).
  - If both masks are zero, both indices are 0.
  - Stage-1 valid follows data_val_i every cycle.
- Illegal masks:
  - A mask with more than one bit set sets illegal_o (sticky until reset).
  - Index is then the lowest set bit of that mask; the entry is still written.
  - One mask zero while the other is nonzero is also illegal; zero = 0 for that entry.
- Stage 2 (FIFO write): on the next edge, if stage-1 valid, entry {left_idx, right_idx, zero} is written at the write pointer.
- Latency: masks sampled at edge E0 appear on outputs with val_o = 1 after edge E1 if the FIFO was empty. FIFO is first-word fall-through; outputs are driven from the read-pointer entry.
- Read: pop on edge where val_o && ready_i.
  - ready_i while empty is ignored.
  - Outputs must not change while val_o && !ready_i.
- Full:
  - Write with usedw_o == DEPTH and no simultaneous pop drops the entry, sets overflow_o (sticky), and leaves pointers unchanged.
  - Write with a simultaneous pop when full is accepted; usedw_o stays DEPTH.
- Simultaneous push and pop at any occupancy: usedw_o unchanged. When empty, push only (no pop possible).
- Pointers: $clog2(DEPTH)+1 bits with wrap bit; full/empty derived from pointers or counter, which must agree with usedw_o.
- Back-to-back data_val_i every cycle with ready_i = 1 sustains 1 entry/cycle.

Decomposition:
- Shared package: entry struct type (left_idx, right_idx, zero) parameterised via IDX_W localparam functions; function onehot_to_idx (lowest-set-bit index, also returns multi-hot flag).
- One sub-module: fwft_fifo (generic DATA_W/DEPTH storage, pointers, usedw, full/empty; async active-low reset).
- Conversion stage stays in the top.

Test Plan:
- Reset mid-stream: load 3 entries, pulse arstn_i low between edges -> val_o = 0, usedw_o = 0 immediately, flags 0.
- Single word: left = 32'h8000_0000, right = 32'h0000_0001, val one cycle, ready_i = 1 -> 2 edges later left_idx_o = 31, right_idx_o = 0, zero_o = 0, val_o for 1 cycle.
- Zero word: masks 0, val -> entry zero_o = 1, indices 0, illegal_o stays 0.
- Fill/overflow: ready_i = 0, 10 consecutive valid words with DEPTH = 8 -> usedw_o = 8, overflow_o = 1. Then draining yields the first 8 in order; words 9-10 are absent.
- Full with simultaneous pop: at usedw_o = 8, ready_i = 1 and a new word each cycle -> no overflow, usedw_o stays 8, order preserved across pointer wrap.
- Illegal mask: data_right_i = 32'h0000_0014 -> illegal_o = 1, right_idx_o = 2; stall (ready_i = 0) holds outputs stable for 5 cycles.

Source files
------------

// File: rtl/onehot_index_fifo_pkg.sv
// Shared types and helpers for the one-hot index FIFO: mask-to-index
// conversion and entry sizing.
package onehot_index_fifo_pkg;

    // Widest mask the conversion helper accepts; narrower masks are zero-extended.
    localparam int MAX_WIDTH = 256;
    localparam int MAX_IDX_W = 8;

    // Result of one mask conversion: lowest-set-bit index plus multi-hot flag.
    typedef struct packed {
        logic                 multi;
        logic [MAX_IDX_W-1:0] idx;
    } idx_res_t;

    // Bits in one buffered entry: {left_idx, right_idx, zero}.
    function automatic int entry_w(input int idx_w);
        return 2 * idx_w + 1;
    endfunction

    // Index of the lowest set bit. An all-zero mask gives index 0.
    // multi flags a mask with more than one bit set.
    function automatic idx_res_t onehot_to_idx(input logic [MAX_WIDTH-1:0] mask);
        idx_res_t res;
        logic     found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (mask[i]) begin
                if (found) begin
                    res.multi = 1'b1;
                end else begin
                    res.idx = MAX_IDX_W'(i);
                    found   = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_index_fifo_if.sv
// Bus between the encoder stage, this block and the downstream consumer.
interface onehot_index_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int UW    = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_val_i;
    logic [IDX_W-1:0] left_idx_o;
    logic [IDX_W-1:0] right_idx_o;
    logic             zero_o;
    logic             val_o;
    logic             ready_i;
    logic [UW-1:0]    usedw_o;
    logic             overflow_o;
    logic             illegal_o;

    // Environment side: drives masks and consumer ready.
    modport master (
        output data_left_i, data_right_i, data_val_i, ready_i,
        input  left_idx_o, right_idx_o, zero_o, val_o, usedw_o, overflow_o, illegal_o
    );

    // Block side.
    modport slave (
        input  data_left_i, data_right_i, data_val_i, ready_i,
        output left_idx_o, right_idx_o, zero_o, val_o, usedw_o, overflow_o, illegal_o
    );
endinterface

// File: rtl/onehot_index_fifo_fwft_fifo.sv
// Generic first-word-fall-through FIFO. Pointers carry a wrap bit so full
// and empty come straight from the pointer difference.
module fwft_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   usedw_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              rd_fire;
    logic              wr_fire;

    assign usedw_o = wptr_q - rptr_q;
    assign empty_o = (usedw_o == '0);
    assign full_o  = (usedw_o == (AW + 1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a write into a full FIFO
    // alongside a pop is still accepted.
    assign rd_fire = rd_en_i && !empty_o;
    assign wr_fire = wr_en_i && (!full_o || rd_fire);
    assign drop_o  = wr_en_i && full_o && !rd_fire;

    // Outputs read 0 while empty so stale storage never shows.
    assign rd_data_o = empty_o ? '0 : mem[rptr_q[AW-1:0]];

    // Next pointer values.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_fire) wptr_d = wptr_q + 1'b1;
        if (rd_fire) rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/onehot_index_fifo.sv
// Converts left/right one-hot masks from the priority encoder into binary
// indices plus a zero-word flag and buffers them for a ready/valid consumer.
module onehot_index_fifo
    import onehot_index_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    onehot_index_fifo_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int ENT_W = entry_w(IDX_W);

    typedef struct packed {
        logic [IDX_W-1:0] left_idx;
        logic [IDX_W-1:0] right_idx;
        logic             zero;
    } entry_t;

    logic [MAX_WIDTH-1:0] lmask, rmask;
    idx_res_t             lres, rres;
    entry_t               conv_d;
    logic                 illegal_now;
    logic                 unused_idx_hi;

    entry_t               s1_q;
    logic                 s1_vld_q;
    logic                 illegal_q;
    logic                 overflow_q;

    logic [ENT_W-1:0]     rd_data;
    entry_t               rd_ent;
    logic                 empty;
    logic                 full;
    logic                 drop;

    // Convert both masks; an illegal entry keeps the lowest set bit and is
    // still buffered, only the sticky flag records it.
    always_comb begin
        lmask                 = '0;
        rmask                 = '0;
        lmask[WIDTH-1:0]      = bus.data_left_i;
        rmask[WIDTH-1:0]      = bus.data_right_i;
        lres                  = onehot_to_idx(lmask);
        rres                  = onehot_to_idx(rmask);
        conv_d.left_idx       = lres.idx[IDX_W-1:0];
        conv_d.right_idx      = rres.idx[IDX_W-1:0];
        conv_d.zero           = (bus.data_left_i == '0) && (bus.data_right_i == '0);
        illegal_now           = bus.data_val_i &&
                                (lres.multi || rres.multi ||
                                 ((bus.data_left_i == '0) != (bus.data_right_i == '0)));
    end

    assign unused_idx_hi = ^{lres.idx, rres.idx, full};

    // Stage 1: conversion register; valid tracks data_val_i every cycle.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= bus.data_val_i;
            if (bus.data_val_i) s1_q <= conv_d;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            illegal_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (illegal_now) illegal_q  <= 1'b1;
            if (drop)        overflow_q <= 1'b1;
        end
    end

    // Stage 2: the FIFO write; the encoder cannot stall, so a full FIFO drops.
    fwft_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .wr_en_i   (s1_vld_q),
        .wr_data_i (s1_q),
        .rd_en_i   (bus.ready_i),
        .rd_data_o (rd_data),
        .empty_o   (empty),
        .full_o    (full),
        .usedw_o   (bus.usedw_o),
        .drop_o    (drop)
    );

    assign rd_ent          = rd_data;
    assign bus.left_idx_o  = rd_ent.left_idx;
    assign bus.right_idx_o = rd_ent.right_idx;
    assign bus.zero_o      = rd_ent.zero;
    assign bus.val_o       = !empty;
    assign bus.overflow_o  = overflow_q;
    assign bus.illegal_o   = illegal_q;

endmodule
